// File: rtl/stack_pkg.sv
// Shared encodings for the stack engine: op codes, FSM states and op-class helpers.
package stack_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_LDSP = 3'b101;
    localparam logic [2:0] OP_PEEK = 3'b110;
    localparam logic [2:0] OP_CLRF = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RDW  = 2'd3
    } state_t;

    function automatic logic is_push_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET) || (op == OP_PEEK);
    endfunction

endpackage

// File: rtl/stack_engine.sv
// Stack unit: owns the downward-growing stack pointer and drives a synchronous
// single-port RAM for PUSH/POP/CALL/RET/PEEK, with overflow/underflow faulting.
module stack_engine
    import stack_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int STACK_BASE  = 1023,
    parameter int STACK_DEPTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [2:0]                         op,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [DATA_W-1:0]                  pc_in,
    input  logic [ADDR_W-1:0]                  sp_in,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic                               done,
    output logic                               err,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               ret_valid,
    output logic [ADDR_W-1:0]                  sp,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
    output logic                               fault
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(STACK_BASE);
    localparam logic [CW-1:0]     DEPTH_C = CW'(STACK_DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(STACK_DEPTH);

    state_t              state, state_nx;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   ldsp_q;
    logic                fail_q;
    logic                mem_wr_q;
    logic [DATA_W-1:0]   rd_q;

    logic                accept;
    logic                full;
    logic                empty;
    logic                ldsp_ok;
    logic                fail_nx;
    logic [ADDR_W-1:0]   ldsp_gap;

    // Handshake: a request transfers on a rising clk edge where op_valid && op_ready;
    // op_ready is high only in IDLE, and a request offered while busy is dropped, not queued.
    assign accept = op_valid && op_ready;

    always_comb begin
        full     = (count == DEPTH_C);
        empty    = (count == '0);
        ldsp_gap = BASE_A - sp_in;
        ldsp_ok  = (sp_in <= BASE_A) && ({1'b0, ldsp_gap} <= DEPTH_W);
        fail_nx  = (is_push_op(op) && full) ||
                   (is_read_op(op) && empty) ||
                   ((op == OP_LDSP) && !ldsp_ok);
    end

    // Every op that does not read RAM completes through S_WR; mem_wr_q gates the actual write.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = (is_read_op(op) && !empty) ? S_RD : S_WR;
            S_WR:    state_nx = S_IDLE;
            S_RD:    state_nx = S_RDW;
            S_RDW:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sp       <= BASE_A;
            count    <= '0;
            fault    <= 1'b0;
            op_q     <= OP_NOP;
            wdata_q  <= '0;
            ldsp_q   <= '0;
            fail_q   <= 1'b0;
            mem_wr_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q     <= op;
                wdata_q  <= (op == OP_CALL) ? pc_in : wr_data;
                ldsp_q   <= sp_in;
                fail_q   <= fail_nx;
                mem_wr_q <= is_push_op(op) && !full;
            end
            case (state)
                S_WR: begin
                    if (fail_q) begin
                        fault <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_PUSH, OP_CALL: begin
                                sp    <= sp - ADDR_W'(1);
                                count <= count + CW'(1);
                            end
                            OP_LDSP: begin
                                sp    <= ldsp_q;
                                count <= CW'(BASE_A - ldsp_q);
                            end
                            OP_CLRF: fault <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_RDW: begin
                    rd_q <= mem_rdata;
                    if (op_q != OP_PEEK) begin
                        sp    <= sp + ADDR_W'(1);
                        count <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // rd_data shows the RAM word during the done cycle and holds it afterwards.
    always_comb begin
        op_ready  = (state == S_IDLE);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        ret_valid = 1'b0;
        rd_data   = rd_q;
        case (state)
            S_WR: begin
                done   = 1'b1;
                err    = fail_q;
                mem_en = mem_wr_q;
                mem_we = mem_wr_q;
                if (mem_wr_q) begin
                    mem_addr  = sp;
                    mem_wdata = wdata_q;
                end
            end
            S_RD: begin
                mem_en   = 1'b1;
                mem_addr = sp + ADDR_W'(1);
            end
            S_RDW: begin
                done      = 1'b1;
                rd_data   = mem_rdata;
                ret_valid = (op_q == OP_RET);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: a count-based stack model predicts every
// completion and every RAM access; monitors compare as the DUT presents them.
module tb_stack_engine;
    import stack_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BASE  = 1023;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    op;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] pc_in;
    logic [AW-1:0] sp_in;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          done;
    logic          err;
    logic [DW-1:0] rd_data;
    logic          ret_valid;
    logic [AW-1:0] sp;
    logic [CW-1:0] count;
    logic          fault;

    always #5 clk = ~clk;

    stack_engine #(
        .DATA_W(DW), .ADDR_W(AW), .STACK_BASE(BASE), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .wr_data(wr_data), .pc_in(pc_in), .sp_in(sp_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .done(done), .err(err), .rd_data(rd_data), .ret_valid(ret_valid),
        .sp(sp), .count(count), .fault(fault)
    );

    // External synchronous RAM, one-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic          err;
        logic          ret;
        logic [DW-1:0] rd;
        logic [AW-1:0] sp;
        logic [CW-1:0] cnt;
        logic          flt;
        logic [31:0]   cyc;
    } resp_t;
    localparam int EW = $bits(resp_t);

    logic [EW-1:0]    exp_q[$];
    logic [AW+DW-1:0] wr_q[$];
    logic [AW-1:0]    rda_q[$];

    // Reference model: the stack is fully described by its depth; the top lives at BASE-cnt+1.
    int            cnt_m;
    logic          fault_m;
    logic [DW-1:0] rd_m;
    logic [DW-1:0] mem_m [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] fill(input int a);
        return 32'hA500_0000 ^ (a * 32'h0000_0101);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [DW-1:0] d, input logic [DW-1:0] pc,
                         input logic [AW-1:0] s, input bit junk);
        resp_t         e;
        int            n;
        int            a;
        int            lat;
        bit            fail;
        logic [DW-1:0] v;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            return;
        end
        e    = '0;
        lat  = 1;
        fail = 1'b0;
        case (o)
            OP_PUSH, OP_CALL: begin
                if (cnt_m == DEPTH) fail = 1'b1;
                else begin
                    a = BASE - cnt_m;
                    v = (o == OP_CALL) ? pc : d;
                    wr_q.push_back({AW'(a), v});
                    mem_m[a] = v;
                    cnt_m++;
                end
            end
            OP_POP, OP_RET, OP_PEEK: begin
                if (cnt_m == 0) fail = 1'b1;
                else begin
                    a = BASE - cnt_m + 1;
                    rda_q.push_back(AW'(a));
                    rd_m  = mem_m[a];
                    lat   = 2;
                    e.ret = (o == OP_RET);
                    if (o != OP_PEEK) cnt_m--;
                end
            end
            OP_LDSP: begin
                if (int'(s) <= BASE && BASE - int'(s) <= DEPTH) cnt_m = BASE - int'(s);
                else fail = 1'b1;
            end
            OP_CLRF: fault_m = 1'b0;
            default: ;
        endcase
        if (fail) fault_m = 1'b1;
        e.err = fail;
        e.rd  = rd_m;
        e.sp  = AW'(BASE - cnt_m);
        e.cnt = CW'(cnt_m);
        e.flt = fault_m;
        e.cyc = 32'(cyc + lat);
        exp_q.push_back(e);
        op = o; wr_data = d; pc_in = pc; sp_in = s; op_valid = 1'b1;
        @(posedge clk);
        #1;
        if (junk) begin
            op = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
    endtask

    // Completion monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = resp_t'(exp_q.pop_front());
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("err", 64'(err), 64'(e.err));
                    chk("ret_valid", 64'(ret_valid), 64'(e.ret));
                    chk("rd_data", 64'(rd_data), 64'(e.rd));
                    @(negedge clk);
                    chk("sp", 64'(sp), 64'(e.sp));
                    chk("count", 64'(count), 64'(e.cnt));
                    chk("fault", 64'(fault), 64'(e.flt));
                end
            end
        end
    end

    // RAM port monitor.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                if (wr_q.size() == 0) chk("unexpected_write", 64'(mem_addr), 64'h3ff_dead);
                else chk("write_addr_data", 64'({mem_addr, mem_wdata}), 64'(wr_q.pop_front()));
            end else begin
                if (rda_q.size() == 0) chk("unexpected_read", 64'(mem_addr), 64'h3ff_dead);
                else chk("read_addr", 64'(mem_addr), 64'(rda_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int r;
        logic [2:0]    o;
        logic [AW-1:0] s;
        rst = 1'b1; op = OP_NOP; op_valid = 1'b0; wr_data = '0; pc_in = '0; sp_in = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = fill(i);
            mem_m[i] = fill(i);
        end
        cnt_m = 0; fault_m = 1'b0; rd_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_sp", 64'(sp), 64'(BASE));
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;

        issue(OP_PUSH, 32'hDEAD_BEEF, '0, '0, 1'b0);
        issue(OP_POP,  '0, '0, '0, 1'b0);
        issue(OP_PUSH, 32'h11, '0, '0, 1'b0);
        issue(OP_PUSH, 32'h22, '0, '0, 1'b1);
        issue(OP_POP,  '0, '0, '0, 1'b0);
        issue(OP_POP,  '0, '0, '0, 1'b1);
        issue(OP_CALL, 32'hFFFF, 32'h40, '0, 1'b0);
        issue(OP_RET,  '0, '0, '0, 1'b0);
        issue(OP_PEEK, '0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) issue(OP_PUSH, 32'h100 + 32'(i), '0, '0, 1'b0);
        issue(OP_CLRF, '0, '0, '0, 1'b0);
        issue(OP_LDSP, '0, '0, 10'd1000, 1'b0);
        issue(OP_LDSP, '0, '0, 10'd1021, 1'b0);
        issue(OP_PEEK, '0, '0, '0, 1'b0);
        issue(OP_NOP,  '0, '0, '0, 1'b0);

        // Reset landing in the RD cycle of a POP.
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        op = OP_POP; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("abort_rd_mem_en", 64'(mem_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_mem_en", 64'(mem_en), 64'd0);
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0; fault_m = 1'b0; rd_m = '0;
        #1;
        chk("abort_sp", 64'(sp), 64'(BASE));
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_op_ready", 64'(op_ready), 64'd1);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2, 3, 14, 15: o = OP_PUSH;
                4:       o = OP_CALL;
                5, 6, 7: o = OP_POP;
                8:       o = OP_RET;
                9:       o = OP_PEEK;
                10, 11:  o = OP_LDSP;
                12:      o = OP_CLRF;
                default: o = OP_NOP;
            endcase
            if ($urandom_range(0, 3) == 0) s = AW'($urandom_range(0, 1023));
            else                           s = AW'(BASE - $urandom_range(0, 6));
            issue(o, $urandom, $urandom, s, 1'($urandom_range(0, 1)));
        end

        repeat (6) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("rda_q_drained", 64'(rda_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised successor to the fixed SP control path: a sequential stack unit that owns the stack pointer and drives a synchronous single-port data RAM for PUSH/POP/CALL/RET/PEEK.
- Adds a request/ready handshake, configurable width, base and depth, and overflow/underflow detection with a sticky fault flag.
- Sits between the control unit (op requests) and the data-memory port mux; RET data feeds the PC mux.

Parameters:
- DATA_W, 32, width of stack words, pc_in and rd_data.
- ADDR_W, 10, data-memory address width.
- STACK_BASE, 1023, address of the first (bottom) stack slot; the stack grows downward.
- STACK_DEPTH, 64, maximum number of entries. Must satisfy STACK_DEPTH <= STACK_BASE+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- op  in  3  000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 LDSP, 110 PEEK, 111 CLRF.
- op_valid  in  1  request strobe.
- op_ready  out  1  engine idle; a request is accepted when op_valid&&op_ready.
- wr_data  in  DATA_W  PUSH operand.
- pc_in  in  DATA_W  return address written by CALL.
- sp_in  in  ADDR_W  new SP for LDSP.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; that op faulted.
- rd_data  out  DATA_W  POP/RET/PEEK result, held until the next read completes.
- ret_valid  out  1  pulses with done for a successful RET.
- sp  out  ADDR_W  current SP (next free slot).
- count  out  $clog2(STACK_DEPTH+1)  live entry count.
- fault  out  1  sticky: set by any err, cleared by CLRF or reset.

Behaviour:
- Reset (async, immediate): sp=STACK_BASE, count=0, state IDLE, op_ready=1; all other outputs 0. Reset mid-operation aborts the op and deasserts mem_en/mem_we with no further write.
- Requests are accepted only in IDLE. op_valid while op_ready=0 is ignored; the op is not queued.
- States: IDLE, WR, RD, RDW.
- PUSH/CALL, count<STACK_DEPTH:
  - Accept -> WR.
  - WR drives mem_en=1, mem_we=1, mem_addr=sp, mem_wdata=wr_data (PUSH) or pc_in (CALL), all captured at accept.
  - WR end: sp<=sp-1, count+1, done=1, then IDLE. Latency is 1 cycle after accept.
- PUSH/CALL, count==STACK_DEPTH (overflow): no RAM access; done=1, err=1, fault<=1 the cycle after accept; sp and count unchanged.
- POP/RET/PEEK, count>0:
  - Accept -> RD.
  - RD drives mem_en=1, mem_we=0, mem_addr=sp+1.
  - RD -> RDW.
  - RDW: rd_data<=mem_rdata, done=1. POP/RET also do sp<=sp+1, count-1. RET also pulses ret_valid. PEEK leaves sp and count unchanged. Latency is 2 cycles.
- POP/RET/PEEK, count==0 (underflow): done=1, err=1, fault<=1 the next cycle; no RAM access; rd_data unchanged.
- LDSP:
  - If STACK_BASE-sp_in <= STACK_DEPTH (with sp_in<=STACK_BASE): sp<=sp_in, count<=STACK_BASE-sp_in, done=1 next cycle.
  - Otherwise done=1, err=1, fault<=1; sp and count unchanged.
- CLRF: fault<=0, done=1 next cycle. NOP: done=1 next cycle, no other effect.
- op_ready=0 from the cycle after accept through the done cycle; it returns to 1 the cycle after done.
- Outside WR/RD, mem_en=0 and mem_we=0.
- Address arithmetic is modulo 2^ADDR_W. The count checks guarantee that a legal op never wraps past STACK_BASE or below STACK_BASE-STACK_DEPTH+1.
- An err on the same cycle as a CLRF cannot occur (one op at a time).

Decomposition:
- Shared package stack_pkg holds the op encoding constants (OP_NOP..OP_CLRF) and the state enum (S_IDLE, S_WR, S_RD, S_RDW).
- Single module. No sub-module is needed; SP and count bookkeeping and the FSM are one always block plus output decode.

Test Plan:
- Reset then PUSH 0xDEADBEEF -> WR cycle with mem_addr=1023, mem_we=1; done 1 cycle after accept; sp=1022, count=1.
- PUSH 0x11, PUSH 0x22, POP, POP (RAM model with 1-cycle latency) -> rd_data 0x22 then 0x11; done 2 cycles after each accept; final sp=1023, count=0.
- CALL pc_in=0x40, then RET -> RAM[1023]=0x40; RET done with rd_data=0x40 and ret_valid=1; PEEK afterwards -> err=1, fault=1.
- STACK_DEPTH=4: five PUSHes -> the fifth gives err=1 with no mem_we; count=4, sp=1019; CLRF -> fault=0.
- LDSP sp_in=1000 -> err (23>4 at depth 4); LDSP sp_in=1021 -> sp=1021, count=2, no err.
- Assert rst during the RD cycle of a POP -> mem_en drops immediately; sp=1023, count=0, no done; op_ready=1 after release.
